// File: rtl/rpi_serial_rx.sv
// Raspberry Pi serial receiver: oversamples the asynchronous Pi bit clock,
// data and frame lines on clk_in, deserializes MSB-first words and hands
// them to the audio datapath through a valid/ack register. Framing errors,
// mid-word timeouts and overruns are reported as single-cycle pulses.
module rpi_serial_rx #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  rpi_clk,
  input  logic                  rpi_data,
  input  logic                  rpi_frame,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH) + 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // Synchronizer and edge-detect registers
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic frame_s1_q, frame_s2_q;

  // Receive state
  state_e                state_q, state_d;
  logic [WORD_WIDTH-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  // Output registers
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  // Combinational helpers
  logic                  rise_c;
  logic                  word_done_c;
  logic [WORD_WIDTH-1:0] word_c;

  assign rise_c = clk_s2_q & ~clk_prev_q;
  // The shift register keeps only the first W-1 bits; the final bit is
  // taken straight from the synchronizer when the word completes.
  assign word_c = {shift_q, data_s2_q};

  // Two-flop synchronizers for the Pi lines plus the delayed clock for edge detect
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      data_s1_q  <= 1'b0;
      data_s2_q  <= 1'b0;
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
    end else begin
      clk_s1_q   <= rpi_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= rpi_data;
      data_s2_q  <= data_s1_q;
      frame_s1_q <= rpi_frame;
      frame_s2_q <= frame_s1_q;
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, shifting, timeout and handshake logic
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    word_done_c   = 1'b0;

    // Consumer acknowledge drops the pending flag on the next edge
    if (data_ack && data_valid_q) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (frame_s2_q) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end

      SHIFT: begin
        // A falling frame wins over a coincident clock edge
        if (!frame_s2_q) begin
          state_d       = IDLE;
          frame_error_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          tmo_d         = '0;
        end else if (rise_c) begin
          shift_d = word_c[WORD_WIDTH-2:0];
          tmo_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            word_done_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (bit_cnt_q != '0) begin
          // Stalled mid-word: abort once the counter reaches its last value
          if (tmo_q == TMO_LAST) begin
            frame_error_d = 1'b1;
            state_d       = WAIT_LOW;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      WAIT_LOW: begin
        if (!frame_s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A completed word always loads; overrun only if the old one was never taken
    if (word_done_c) begin
      data_out_d   = word_c;
      data_valid_d = 1'b1;
      overrun_d    = data_valid_q & ~data_ack;
    end

    busy_d = (state_d == SHIFT);
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rpi_serial_rx.sv
// Self-checking bench for rpi_serial_rx: Pi-side transactions against a
// word-level model of data_out / data_valid and error/overrun pulse counts.
module tb_rpi_serial_rx;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 1024;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         rpi_clk;
  logic         rpi_data;
  logic         rpi_frame;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ack;
  logic         frame_error;
  logic         overrun;
  logic         busy;

  rpi_serial_rx #(
    .WORD_WIDTH     (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rpi_clk     (rpi_clk),
    .rpi_data    (rpi_data),
    .rpi_frame   (rpi_frame),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #10 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor: counts high cycles and flags any pulse longer than one cycle
  int   ferr_cnt    = 0;
  int   ovr_cnt     = 0;
  int   stretch_cnt = 0;
  logic ferr_prev   = 1'b0;
  logic ovr_prev    = 1'b0;

  always @(negedge clk_in) begin
    if (frame_error === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if ((frame_error === 1'b1 && ferr_prev) || (overrun === 1'b1 && ovr_prev)) stretch_cnt++;
    ferr_prev = (frame_error === 1'b1);
    ovr_prev  = (overrun === 1'b1);
  end

  // Reference model: what the consumer should see
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  int           m_ferr  = 0;
  int           m_ovr   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_state(input string tag);
    check({tag, ":data_out"},   32'(data_out),   32'(m_data));
    check({tag, ":data_valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, ":frame_err"},  32'(ferr_cnt),   32'(m_ferr));
    check({tag, ":overrun"},    32'(ovr_cnt),    32'(m_ovr));
  endtask

  // One Pi bit: data set during the low half, rising edge mid-period
  task automatic pi_bit(input logic b);
    rpi_data = b;
    cycles(10);
    rpi_clk = 1'b1;
    cycles(10);
    rpi_clk = 1'b0;
  endtask

  task automatic frame_on();
    rpi_frame = 1'b1;
    cycles(10);
  endtask

  task automatic frame_off();
    cycles(10);
    rpi_frame = 1'b0;
    cycles(10);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) pi_bit(w[i]);
    if (m_valid) m_ovr++;
    m_data  = w;
    m_valid = 1'b1;
  endtask

  task automatic ack();
    data_ack = 1'b1;
    cycles(1);
    data_ack = 1'b0;
    m_valid  = 1'b0;
  endtask

  // Final bit's rising edge reaches the receiver on the same clk_in edge
  // that samples data_ack high
  task automatic send_word_ack_on_last(input logic [W-1:0] w);
    for (int i = W - 1; i >= 1; i--) pi_bit(w[i]);
    rpi_data = w[0];
    cycles(10);
    rpi_clk = 1'b1;
    cycles(2);
    data_ack = 1'b1;
    cycles(1);
    data_ack = 1'b0;
    cycles(7);
    rpi_clk = 1'b0;
    m_data  = w;
    m_valid = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rw;
    int           kind;
    int           nb;

    reset     = 1'b1;
    rpi_clk   = 1'b0;
    rpi_data  = 1'b0;
    rpi_frame = 1'b0;
    data_ack  = 1'b0;
    cycles(3);
    check("reset:data_out",    32'(data_out),    32'(0));
    check("reset:data_valid",  32'(data_valid),  32'(0));
    check("reset:frame_error", 32'(frame_error), 32'(0));
    check("reset:overrun",     32'(overrun),     32'(0));
    check("reset:busy",        32'(busy),        32'(0));
    reset = 1'b0;
    cycles(3);

    // Single word then acknowledge
    frame_on();
    check("t1:busy_in_frame", 32'(busy), 32'(1));
    send_word(16'hA53C);
    check_state("t1");
    ack();
    check("t1:ack_clears", 32'(data_valid), 32'(0));
    frame_off();
    check("t1:busy_after", 32'(busy), 32'(0));

    // Back-to-back words without ack produce one overrun
    frame_on();
    send_word(16'h1234);
    check_state("t2a");
    send_word(16'hFFFF);
    check_state("t2b");
    frame_off();

    // Frame drops after 7 bits
    frame_on();
    for (int i = 0; i < 7; i++) pi_bit(1'($urandom));
    frame_off();
    m_ferr++;
    check_state("t3");
    check("t3:busy", 32'(busy), 32'(0));

    // Pi clock stalls mid-word; edges ignored until frame drops
    ack();
    frame_on();
    for (int i = 0; i < 5; i++) pi_bit(1'($urandom));
    cycles(990);
    check("t4:no_early_timeout", 32'(ferr_cnt), 32'(m_ferr));
    check("t4:busy_waiting",     32'(busy),     32'(1));
    cycles(40);
    m_ferr++;
    check("t4:timeout",     32'(ferr_cnt), 32'(m_ferr));
    check("t4:busy_waitlo", 32'(busy),     32'(0));
    for (int i = 0; i < 3; i++) pi_bit(1'b1);
    frame_off();
    check_state("t4_ignored");
    frame_on();
    send_word(16'h0F0F);
    frame_off();
    check_state("t4_new");

    // Completion coincident with ack on a pending word
    frame_on();
    send_word_ack_on_last(16'h5AA5);
    cycles(2);
    check_state("t5");
    frame_off();
    ack();
    check("t5:ack_clears", 32'(data_valid), 32'(0));

    // Randomized traffic
    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1: begin
          frame_on();
          nb = int'($urandom_range(1, 3));
          for (int k = 0; k < nb; k++) send_word(W'($urandom));
          frame_off();
          check_state("rnd_words");
        end
        2: begin
          frame_on();
          nb = int'($urandom_range(1, W - 1));
          for (int k = 0; k < nb; k++) pi_bit(1'($urandom));
          frame_off();
          m_ferr++;
          check_state("rnd_abort");
        end
        default: begin
          frame_on();
          frame_off();
          ack();
          check_state("rnd_ack");
        end
      endcase
    end

    // Reset in the middle of a word
    frame_on();
    send_word(W'($urandom));
    rw = W'($urandom);
    for (int i = W - 1; i >= W - 9; i--) pi_bit(rw[i]);
    reset     = 1'b1;
    rpi_frame = 1'b0;
    rpi_clk   = 1'b0;
    cycles(1);
    check("t6:data_out",    32'(data_out),    32'(0));
    check("t6:data_valid",  32'(data_valid),  32'(0));
    check("t6:frame_error", 32'(frame_error), 32'(0));
    check("t6:overrun",     32'(overrun),     32'(0));
    check("t6:busy",        32'(busy),        32'(0));
    cycles(2);
    reset   = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    cycles(5);
    frame_on();
    send_word(16'h8001);
    frame_off();
    check_state("t6_after");

    check("pulse_width", 32'(stretch_cnt), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
